gate_bist_ctrl: RTL and testbench



---
 rtl/gate_bist_pkg.sv | 26 ++
 rtl/gate_bist_misr.sv | 37 +++
 rtl/gate_bist_ctrl.sv | 140 ++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-library BIST sequencer.
// State encoding, LFSR taps and MISR feedback polynomial.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  // Taps at bits 15,13,12,10 of the Fibonacci LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // x^10 + x^3 + 1
  localparam logic [9:0]  MISR_POLY = 10'h009;
  localparam logic [15:0] SEED_DEF  = 16'h0001;

  function automatic logic [15:0] fix_seed(
    input logic [15:0] s
  );
    return (s == '0) ? SEED_DEF : s;
  endfunction

endpackage

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register with synchronous clear and enable.
// Clear has priority over enable.
import gate_bist_pkg::*;

module gate_bist_misr #(
  parameter int unsigned   W    = 10,
  parameter logic [W-1:0]  POLY = W'(MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = {q_q[W-2:0], 1'b0} ^ d_i;
    if (q_q[W-1]) q_d = q_d ^ POLY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: drives LFSR vectors into a gate model, compacts
// its responses into a MISR and compares against a golden signature.
import gate_bist_pkg::*;

module gate_bist_ctrl #(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned OUT_W      = 10,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_patterns,
  input  logic [IN_W-1:0]  seed,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  localparam logic [IN_W-1:0] TAPS   = IN_W'(LFSR_TAPS);
  localparam logic [IN_W-1:0] SEED0  = IN_W'(SEED_DEF);
  localparam logic [7:0]      SET_LD = 8'(SETTLE_CYC);

  state_e           state_q;
  logic [IN_W-1:0]  lfsr_q;
  logic [IN_W-1:0]  lfsr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_q;
  logic [OUT_W-1:0] golden_q;
  logic [7:0]       set_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [OUT_W-1:0] sig_q;
  logic [OUT_W-1:0] misr_q;
  logic             accept;
  logic             misr_clr;
  logic             misr_en;

  assign lfsr_d   = {lfsr_q[IN_W-2:0], ^(lfsr_q & TAPS)};
  assign accept   = (state_q == ST_IDLE) && start;
  assign misr_clr = abort || accept;
  assign misr_en  = (state_q == ST_CAPTURE);

  gate_bist_misr #(
    .W    (OUT_W),
    .POLY (OUT_W'(MISR_POLY))
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (misr_clr),
    .en_i  (misr_en),
    .d_i   (dut_out),
    .q_o   (misr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED0;
      cnt_q    <= '0;
      n_q      <= '0;
      golden_q <= '0;
      set_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      sig_q    <= '0;
    end else if (abort) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED0;
      cnt_q    <= '0;
      set_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      sig_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q      <= n_patterns;
            golden_q <= golden;
            lfsr_q   <= IN_W'(fix_seed(16'(seed)));
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= (n_patterns == '0) ?
                        ST_COMPARE : ST_APPLY;
          end
        end
        ST_APPLY: begin
          set_q   <= SET_LD;
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          set_q <= set_q - 8'd1;
          if (set_q == 8'd1) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          lfsr_q <= lfsr_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          // Compare before increment so 16'hFFFF never wraps
          if (cnt_q == n_q - CNT_W'(1)) state_q <= ST_COMPARE;
          else                          state_q <= ST_APPLY;
        end
        ST_COMPARE: begin
          sig_q   <= misr_q;
          pass_q  <= (misr_q == golden_q);
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in    = lfsr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl against a sequence-level model.
// Gate stub selectable between constant, loopback and arithmetic hash.
module tb_gate_bist_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] n_patterns = '0;
  logic [15:0] seed = '0;
  logic [9:0]  golden = '0;
  logic [15:0] dut_in;
  logic [9:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [9:0]  signature;

  int ntests = 0;
  int nfail  = 0;
  int mode   = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl #(
    .IN_W       (16),
    .OUT_W      (10),
    .SETTLE_CYC (S),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .n_patterns (n_patterns),
    .seed       (seed),
    .golden     (golden),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
  );

  function automatic logic [9:0] gate(int md, logic [15:0] v);
    case (md)
      0:       return 10'h001;
      1:       return v[9:0];
      default: return v[9:0] + v[15:6] + 10'd37;
    endcase
  endfunction

  always_comb dut_out = gate(mode, dut_in);

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [9:0] misr_step(
    logic [9:0] m, logic [9:0] d
  );
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      r[i] = m[9] ^ d[0];
      else if (i == 3) r[i] = m[2] ^ m[9] ^ d[3];
      else             r[i] = m[i-1] ^ d[i];
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run(int n, logic [15:0] sd, logic [9:0] gold,
                     bit use_model, bit stray, string tag,
                     output logic [9:0] sig_o);
    logic [15:0] v;
    logic [9:0]  m;
    logic [15:0] vecs[$];
    int          t;
    v = (sd == 16'h0) ? 16'h0001 : sd;
    m = '0;
    for (int p = 0; p < n; p++) begin
      vecs.push_back(v);
      m = misr_step(m, gate(mode, v));
      v = lfsr_step(v);
    end
    if (use_model) gold = m;
    sig_o = m;
    t = n * (S + 2) + 2;
    @(negedge clk);
    n_patterns = 16'(n);
    seed       = sd;
    golden     = gold;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    n_patterns = 16'($urandom);
    seed       = 16'($urandom);
    golden     = 10'($urandom);
    for (int k = 1; k <= t + 1; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      chk($sformatf("%s busy@%0d", tag, k), 32'(busy),
          32'(k <= t));
      chk($sformatf("%s done@%0d", tag, k), 32'(done),
          32'(k == t));
      if (k <= n * (S + 2))
        chk($sformatf("%s dut_in@%0d", tag, k), 32'(dut_in),
            32'(vecs[(k - 1) / (S + 2)]));
      if (k >= t) begin
        chk($sformatf("%s sig@%0d", tag, k), 32'(signature),
            32'(m));
        chk($sformatf("%s pass@%0d", tag, k), 32'(pass),
            32'(m == gold));
      end
      if (stray && k == 3) start = 1'b1;
    end
  endtask

  logic [9:0] sg;
  bit         seen;

  initial begin
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst pass", 32'(pass), 32'd0);
    chk("rst sig", 32'(signature), 32'd0);
    chk("rst dut_in", 32'(dut_in), 32'h0001);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0;
    run(1, 16'h0001, 10'h001, 0, 0, "single", sg);
    chk("single sig const", 32'(signature), 32'h001);
    chk("single pass const", 32'(pass), 32'd1);

    run(2, 16'h0001, 10'h003, 0, 1, "two", sg);
    chk("two sig const", 32'(signature), 32'h003);

    mode = 1;
    run(3, 16'h0001, 10'h000, 1, 0, "lfsr", sg);

    mode = 0;
    run(1, 16'h0001, 10'h000, 0, 0, "mismatch", sg);
    chk("mismatch pass const", 32'(pass), 32'd0);

    run(0, 16'h1234, 10'h000, 0, 0, "zero_n", sg);
    chk("zero_n pass const", 32'(pass), 32'd1);

    mode = 2;
    run(2, 16'h0000, 10'h000, 1, 0, "zero_seed", sg);

    for (int i = 0; i < 8; i++) begin
      mode = int'($urandom_range(0, 2));
      run(int'($urandom_range(1, 12)), 16'($urandom),
          10'($urandom), bit'($urandom_range(0, 1)), 1'b0,
          $sformatf("rnd%0d", i), sg);
    end

    mode = 0;
    run(1, 16'h0001, 10'h001, 0, 0, "pre_abort", sg);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort busy", 32'(busy), 32'd0);
    chk("start+abort pass", 32'(pass), 32'd0);
    chk("start+abort sig", 32'(signature), 32'd0);
    @(posedge clk);
    #1;
    chk("start+abort idle", 32'(busy), 32'd0);

    mode = 2;
    @(negedge clk);
    n_patterns = 16'd4;
    seed       = 16'h0005;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort pre busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort sig", 32'(signature), 32'd0);
    chk("abort pass", 32'(pass), 32'd0);
    chk("abort dut_in", 32'(dut_in), 32'h0001);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort quiet", 32'(seen), 32'd0);

    run(2, 16'h00A5, 10'h000, 1, 0, "post_abort", sg);

    @(negedge clk);
    n_patterns = 16'd3;
    seed       = 16'h0777;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst pass", 32'(pass), 32'd0);
    chk("midrst sig", 32'(signature), 32'd0);
    chk("midrst dut_in", 32'(dut_in), 32'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst quiet", 32'(seen), 32'd0);

    run(3, 16'hBEEF, 10'h000, 1, 0, "post_rst", sg);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
